// File: rtl/systolic_pkg.sv
// Shared types for the systolic array edge blocks.
// Module-level widths come from each block's own parameters; these are the defaults.
package systolic_pkg;

  localparam int DEFAULT_ARRAY_WIDTH = 16;
  localparam int DEFAULT_DATA_WIDTH  = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    FULL   = 2'd1,
    STREAM = 2'd2
  } feeder_state_t;

  typedef logic [$clog2(DEFAULT_ARRAY_WIDTH)-1:0] index_t;
  typedef logic signed [DEFAULT_DATA_WIDTH-1:0]   weight_t;

endpackage

// File: rtl/weight_feeder_if.sv
// Tile-load input bus, control and north-edge weight outputs of the weight feeder.
// Master is the tile source / sequencer side, slave is the feeder.
interface weight_feeder_if #(
  parameter int N = 16,
  parameter int W = 8
);
  localparam int IW = $clog2(N);

  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  in_row;
  logic            start;
  logic [N-1:0]    col_enable;
  logic            full;
  logic            busy;
  logic            load_done;
  logic [N-1:0]    col_accept_w;
  logic [N*W-1:0]  col_weight;
  logic [N*IW-1:0] col_index;

  modport master (
    output in_valid, in_row, start, col_enable,
    input  in_ready, full, busy, load_done, col_accept_w, col_weight, col_index
  );

  modport slave (
    input  in_valid, in_row, start, col_enable,
    output in_ready, full, busy, load_done, col_accept_w, col_weight, col_index
  );

endinterface

// File: rtl/weight_tile_buffer.sv
// One weight tile: N rows of N*W bits, synchronous write, combinational read.
module weight_tile_buffer #(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] waddr,
  input  logic [N*W-1:0]       wdata,
  input  logic [$clog2(N)-1:0] raddr,
  output logic [N*W-1:0]       rdata
);

  logic [N*W-1:0] mem [N];

  // NOTE: storage has no reset; a row is always written before the stream can read it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/weight_feeder.sv
// Buffers one weight tile row by row, then streams it to the array's north edge
// in descending index order so every PE row captures on the same edge.
module weight_feeder
  import systolic_pkg::*;
#(
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH_IN        = 8
) (
  input  logic          clk,
  input  logic          rst,
  weight_feeder_if.slave bus
);

  localparam int N  = SYSTOLIC_ARRAY_WIDTH;
  localparam int W  = DATA_WIDTH_IN;
  localparam int IW = $clog2(N);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [1:0] S_FILL   = FILL;
  localparam logic [1:0] S_FULL   = FULL;
  localparam logic [1:0] S_STREAM = STREAM;

  logic [1:0]      state;
  logic [IW-1:0]   wptr;
  logic [IW-1:0]   rptr;
  logic [N-1:0]    en_q;
  logic            load_done_q;
  logic [N-1:0]    accept_q;
  logic [N*W-1:0]  weight_q;
  logic [N*IW-1:0] index_q;

  logic            we;
  logic            launch;
  logic            advance;
  logic [IW-1:0]   rd_idx;
  logic [N-1:0]    en_sel;
  logic [N*W-1:0]  rd_row;
  logic [N-1:0]    accept_d;
  logic [N*W-1:0]  weight_d;
  logic [N*IW-1:0] index_d;

  assign bus.in_ready     = (state == S_FILL) && !rst;
  assign bus.full         = (state == S_FULL);
  assign bus.busy         = (state == S_STREAM);
  assign bus.load_done    = load_done_q;
  assign bus.col_accept_w = accept_q;
  assign bus.col_weight   = weight_q;
  assign bus.col_index    = index_q;

  assign we      = bus.in_valid && bus.in_ready;
  assign launch  = (state == S_FULL) && bus.start;
  assign advance = (state == S_STREAM) && (rptr != '0);

  // The output registers load the row the next beat will present: row N-1 on
  // launch, then one below the currently presented row.
  assign rd_idx = (state == S_STREAM) ? rptr - IW'(1) : LAST;
  assign en_sel = (state == S_STREAM) ? en_q : bus.col_enable;

  weight_tile_buffer #(
    .N (N),
    .W (W)
  ) u_tile_buffer (
    .clk   (clk),
    .we    (we),
    .waddr (wptr),
    .wdata (bus.in_row),
    .raddr (rd_idx),
    .rdata (rd_row)
  );

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    accept_d = '0;
    weight_d = '0;
    index_d  = '0;
    if (launch || advance) begin
      for (int c = 0; c < N; c++) begin
        if (en_sel[c]) begin
          accept_d[c]           = 1'b1;
          weight_d[c*W +: W]    = rd_row[c*W +: W];
          index_d[c*IW +: IW]   = rd_idx;
        end
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FILL;
      wptr        <= '0;
      rptr        <= '0;
      en_q        <= '0;
      load_done_q <= 1'b0;
      accept_q    <= '0;
      weight_q    <= '0;
      index_q     <= '0;
    end else begin
      load_done_q <= 1'b0;
      accept_q    <= accept_d;
      weight_q    <= weight_d;
      index_q     <= index_d;
      case (state)
        S_FILL: begin
          if (we) begin
            if (wptr == LAST) begin
              wptr  <= '0;
              state <= S_FULL;
            end else begin
              wptr <= wptr + IW'(1);
            end
          end
        end
        S_FULL: begin
          if (bus.start) begin
            en_q  <= bus.col_enable;
            rptr  <= LAST;
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (rptr == '0) begin
            state       <= S_FILL;
            load_done_q <= 1'b1;
          end else begin
            rptr <= rptr - IW'(1);
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_feeder.sv
// Directed bench for weight_feeder (N=4, W=8) with a 4x4 PE-column capture model.
module tb_weight_feeder;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_feeder_if #(.N(N), .W(W)) bus ();

  weight_feeder #(
    .SYSTOLIC_ARRAY_WIDTH (N),
    .DATA_WIDTH_IN        (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ld_cyc = 0;

  logic [N*W-1:0] cur_tile [N];

  // Downstream PE model: each row forwards accept/weight/index one hop per
  // cycle and captures the weight whose index equals its row number.
  logic          pa    [N][N];
  logic [IW-1:0] pi    [N][N];
  logic [W-1:0]  pw    [N][N];
  logic [W-1:0]  inact [N][N];
  int            cap   [N][N];

  function automatic logic src_a(input int r, input int c);
    if (r == 0) return bus.col_accept_w[c];
    return pa[r-1][c];
  endfunction

  function automatic logic [IW-1:0] src_i(input int r, input int c);
    if (r == 0) return bus.col_index[c*IW +: IW];
    return pi[r-1][c];
  endfunction

  function automatic logic [W-1:0] src_w(input int r, input int c);
    if (r == 0) return bus.col_weight[c*W +: W];
    return pw[r-1][c];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (rst) begin
          pa[r][c] <= 1'b0;
          pi[r][c] <= '0;
          pw[r][c] <= '0;
        end else begin
          pa[r][c] <= src_a(r, c);
          pi[r][c] <= src_i(r, c);
          pw[r][c] <= src_w(r, c);
          if (src_a(r, c) && src_i(r, c) == IW'(r)) begin
            inact[r][c] <= src_w(r, c);
            cap[r][c]   <= cyc;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [W-1:0] wsel(input logic [31:0] row, input int c);
    return row[c*W +: W];
  endfunction

  task automatic set_tile(input logic [31:0] r0, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] r3);
    cur_tile[0] = r0;
    cur_tile[1] = r1;
    cur_tile[2] = r2;
    cur_tile[3] = r3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int r);
    bus.in_valid = 1'b1;
    bus.in_row   = cur_tile[r];
    tick();
  endtask

  task automatic load_tile();
    for (int r = 0; r < N; r++) begin
      beat(r);
      if (r == 0) check("ld_pulse_end", {31'b0, bus.load_done}, 32'd0);
    end
    bus.in_valid = 1'b0;
    check("fill_full", {31'b0, bus.full}, 32'd1);
    check("fill_ready", {31'b0, bus.in_ready}, 32'd0);
    check("fill_busy", {31'b0, bus.busy}, 32'd0);
  endtask

  // Start in FULL, check all N stream beats and the load_done cycle.
  // With bp set, in_valid stays high with a junk row for the whole stream.
  task automatic run_stream(input logic [N-1:0] en, input bit bp);
    int idx;
    bus.start      = 1'b1;
    bus.col_enable = en;
    if (bp) begin
      bus.in_valid = 1'b1;
      bus.in_row   = 32'hAAAA_AAAA;
    end
    tick();
    bus.start      = 1'b0;
    bus.col_enable = ~en;
    for (int j = 0; j < N; j++) begin
      idx = N - 1 - j;
      check($sformatf("busy[%0d]", j), {31'b0, bus.busy}, 32'd1);
      check($sformatf("accept[%0d]", j), {28'b0, bus.col_accept_w}, {28'b0, en});
      if (bp) check($sformatf("bp_ready[%0d]", j), {31'b0, bus.in_ready}, 32'd0);
      for (int c = 0; c < N; c++) begin
        check($sformatf("weight[%0d][c%0d]", j, c), {24'b0, bus.col_weight[c*W +: W]},
              en[c] ? {24'b0, wsel(cur_tile[idx], c)} : 32'd0);
        check($sformatf("index[%0d][c%0d]", j, c), {30'b0, bus.col_index[c*IW +: IW]},
              en[c] ? 32'(idx) : 32'd0);
      end
      tick();
    end
    ld_cyc = cyc;
    check("done_pulse", {31'b0, bus.load_done}, 32'd1);
    check("done_busy", {31'b0, bus.busy}, 32'd0);
    check("done_accept", {28'b0, bus.col_accept_w}, 32'd0);
    check("done_weight", bus.col_weight, 32'd0);
    check("done_index", {24'b0, bus.col_index}, 32'd0);
    check("done_ready", {31'b0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb, dones;
    int t_done [2];
    logic rdy;
    logic [W-1:0] exp_c0 [N];
    logic [W-1:0] exp_c3 [N];

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_row     = '0;
    bus.start      = 1'b0;
    bus.col_enable = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        inact[r][c] = '0;
        cap[r][c]   = 0;
      end

    // Reset state
    repeat (3) tick();
    check("rst_ready", {31'b0, bus.in_ready}, 32'd0);
    check("rst_full", {31'b0, bus.full}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.load_done}, 32'd0);
    check("rst_accept", {28'b0, bus.col_accept_w}, 32'd0);
    check("rst_weight", bus.col_weight, 32'd0);
    check("rst_index", {24'b0, bus.col_index}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", {31'b0, bus.in_ready}, 32'd1);

    // Basic load and PE capture alignment
    set_tile(mk(1, 2, 3, 4), mk(5, 6, 7, 8), mk(9, 10, 11, 12), mk(-1, -2, -3, -4));
    load_tile();
    run_stream(4'b1111, 1'b0);
    exp_c0 = '{8'd1, 8'd5, 8'd9, 8'hFF};
    exp_c3 = '{8'd4, 8'd8, 8'd12, 8'hFC};
    for (int r = 0; r < N; r++) begin
      check($sformatf("pe_r%0d_c0", r), {24'b0, inact[r][0]}, {24'b0, exp_c0[r]});
      check($sformatf("pe_r%0d_c3", r), {24'b0, inact[r][3]}, {24'b0, exp_c3[r]});
      check($sformatf("pe_cap_r%0d_c0", r), cap[r][0], ld_cyc - 1);
      check($sformatf("pe_cap_r%0d_c3", r), cap[r][3], ld_cyc - 1);
    end

    // Column mask
    set_tile(mk(10, 20, 30, 40), mk(-10, -20, -30, -40), mk(50, 60, 70, 80), mk(127, -128, 1, -1));
    load_tile();
    run_stream(4'b0101, 1'b0);

    // Start outside FULL is ignored
    set_tile(mk(3, 1, 4, 1), mk(5, 9, 2, 6), mk(-5, -3, 5, 8), mk(9, 7, -9, 3));
    beat(0);
    beat(1);
    bus.in_valid   = 1'b0;
    bus.start      = 1'b1;
    bus.col_enable = 4'b1111;
    tick();
    bus.start = 1'b0;
    check("early_start_busy", {31'b0, bus.busy}, 32'd0);
    check("early_start_full", {31'b0, bus.full}, 32'd0);
    check("early_start_accept", {28'b0, bus.col_accept_w}, 32'd0);
    check("early_start_ready", {31'b0, bus.in_ready}, 32'd1);
    beat(2);
    beat(3);
    bus.in_valid = 1'b0;
    check("late_fill_full", {31'b0, bus.full}, 32'd1);
    run_stream(4'b1111, 1'b0);

    // Backpressure: valid held through the stream, next tile starts in the load_done cycle
    set_tile(mk(-7, 7, -7, 7), mk(100, -100, 33, -33), mk(2, 4, 8, 16), mk(-2, -4, -8, -16));
    load_tile();
    run_stream(4'b1111, 1'b1);
    set_tile(mk(21, 22, 23, 24), mk(25, 26, 27, 28), mk(29, 30, 31, 32), mk(33, 34, 35, 36));
    load_tile();
    run_stream(4'b1111, 1'b0);

    // Reset mid-stream
    set_tile(mk(-50, 51, -52, 53), mk(60, 61, 62, 63), mk(70, 71, 72, 73), mk(80, 81, 82, 83));
    load_tile();
    bus.start      = 1'b1;
    bus.col_enable = 4'b1111;
    tick();
    bus.start = 1'b0;
    check("mid_idx3", {30'b0, bus.col_index[1:0]}, 32'd3);
    tick();
    check("mid_idx2", {30'b0, bus.col_index[1:0]}, 32'd2);
    rst = 1'b1;
    tick();
    check("mid_rst_accept", {28'b0, bus.col_accept_w}, 32'd0);
    check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("mid_rst_full", {31'b0, bus.full}, 32'd0);
    check("mid_rst_weight", bus.col_weight, 32'd0);
    check("mid_rst_index", {24'b0, bus.col_index}, 32'd0);
    check("mid_rst_ready", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("mid_no_done[%0d]", k), {31'b0, bus.load_done}, 32'd0);
      check($sformatf("mid_idle_busy[%0d]", k), {31'b0, bus.busy}, 32'd0);
    end
    check("mid_ready", {31'b0, bus.in_ready}, 32'd1);
    set_tile(mk(1, 2, 3, 4), mk(5, 6, 7, 8), mk(9, 10, 11, 12), mk(-1, -2, -3, -4));
    load_tile();
    run_stream(4'b1111, 1'b0);

    // Back-to-back tiles: after load_done, N fill edges, one start edge in
    // FULL and N stream edges give 2N+1 edges between pulses.
    set_tile(mk(10, 20, 30, 40), mk(-10, -20, -30, -40), mk(50, 60, 70, 80), mk(127, -128, 1, -1));
    bus.start      = 1'b1;
    bus.col_enable = 4'b1111;
    bus.in_valid   = 1'b1;
    nb    = 0;
    dones = 0;
    for (int k = 0; k < 60 && dones < 2; k++) begin
      bus.in_row = cur_tile[nb % N];
      rdy = bus.in_ready;
      tick();
      if (rdy) nb++;
      if (bus.load_done) begin
        t_done[dones] = cyc;
        dones++;
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check("b2b_dones", dones, 32'd2);
    if (dones == 2) check("b2b_gap", t_done[1] - t_done[0], 2 * N + 1);
    check("b2b_beats", nb, 2 * N);
    tick();
    check("b2b_idle_ready", {31'b0, bus.in_ready}, 32'd1);
    check("b2b_idle_full", {31'b0, bus.full}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
